instr_loader: RTL and testbench
===============================

# instr_loader

Program loader for the instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially from address 0 into the instruction memory's synchronous write port. It holds the core in reset while loading, so testbenches and the board bring-up path both load programs through this block.

## Interface
- ADDR_W, 7: instruction memory address width.
- DEPTH, 128: instruction memory entries; maximum load length in words.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE.
- nwords  in  8  number of words to load, sampled on start; values above DEPTH are clamped to DEPTH.
- in_valid  in  1  byte source has a byte.
- in_byte  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write enable.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  write data.
- busy  out  1  load in progress (RECV or WRITE).
- done  out  1  load finished; held until the next start or rst.
- cpu_hold  out  1  core reset request; high from rst until done.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE: in_ready=0, mem_we=0.
  - start with clamped nwords=0 -> DONE; no writes.
  - start with nwords>0 -> RECV; word counter, byte counter and mem_addr are cleared.
- RECV: in_ready=1. A byte transfers on an edge where in_valid&in_ready. Byte k (0..3) lands in shift bits [8k+7:8k]. The 4th transfer moves the state to WRITE.
- WRITE: exactly one cycle. in_ready=0, mem_we=1, mem_addr is the current word index, mem_wdata is the assembled word. On exit, the word count increments and mem_addr increments.
  - If count == nwords -> DONE.
  - Otherwise -> RECV.
- DONE: done=1, cpu_hold=0, busy=0, in_ready=0. start -> restarts as from IDLE (reload).
- Start while busy is ignored. nwords is latched; later changes have no effect.
- mem_addr never wraps: the clamp guarantees a final address of at most DEPTH-1. With DEPTH=128, a full load ends at address 127.
- rst in any state:
  - next state IDLE; all counters cleared; partial word discarded.
  - Outputs: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, cpu_hold=1.
  - No write may occur on the reset edge.

## Timing
- Reset values: all outputs 0 except cpu_hold=1.
- start at edge E -> in_ready=1 in the cycle after E.
- 4th byte accepted at edge N -> mem_we=1 during cycle N+1 -> memory written at edge N+2 -> in_ready=1 again in cycle N+2.
- Throughput: one word per 5 cycles with in_valid held high.
- Last write edge W -> done=1 and cpu_hold=0 in the cycle after W.
- in_byte is ignored when in_valid=0 or in_ready=0. Stalls of any length in RECV are legal.

## Structure
- Shared package (instr_pkg): the IM_ADDR_W=7 and IM_DEPTH=128 constants and the loader state enum, so the instruction memory and the loader agree.
- Natural sub-module: byte_packer, a 4-byte little-endian assembler with count and word-complete flag. The FSM, counters and write-port drive stay in instr_loader.

## Test plan
- Reset values: rst high for 2 cycles -> all outputs 0, cpu_hold=1; start without rst -> normal load.
- Single word: start, nwords=1, bytes 0x13,0x00,0x50,0x00 back to back -> one mem_we pulse with addr 0 and wdata 0x00500013, then done=1 and cpu_hold=0.
- Full load with stalls: nwords=200 (clamped to 128), in_valid toggled pseudo-randomly.
  - Exactly 128 writes at addrs 0..127, each wdata = {4i+3,4i+2,4i+1,4i} (mod 256).
  - No write at 128.
- Zero length: nwords=0 -> done=1 the cycle after start; no mem_we; in_ready never asserted.
- Mid-load reset: rst asserted after 2 bytes of word 3 -> no further writes, state IDLE, cpu_hold=1. A reload of 2 words then writes addrs 0 and 1 only.
- Start while busy ignored: a start pulse during RECV of a 4-word load is ignored -> exactly 4 writes. A reload from DONE with nwords=2 -> done drops, 2 writes, done rises.

Source files
------------

// File: rtl/instr_pkg.sv
// instr_pkg
// Purpose: constants and types shared by the instruction memory and its
// program loader, so both sides agree on address width, depth and loader
// state encoding.
// Contents:
//   IM_ADDR_W      instruction memory address width
//   IM_DEPTH       instruction memory entries
//   loader_state_t loader FSM state encoding
//   clamp_nwords   limits a requested load length to the memory depth
package instr_pkg;

  localparam int IM_ADDR_W = 7;
  localparam int IM_DEPTH  = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

  function automatic logic [7:0] clamp_nwords(input logic [7:0] n, input int depth);
    if (int'(n) > depth) return 8'(depth);
    return n;
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// instr_loader_if
// Purpose: groups the loader's byte-stream handshake and the instruction
// memory write port.
// Signals:
//   in_valid   byte source has a byte
//   in_byte    stream byte
//   in_ready   loader accepts a byte this cycle
//   mem_we     instruction memory write enable
//   mem_addr   write address
//   mem_wdata  write data
// Modports: slave = loader side, master = byte source / memory model side.
interface instr_loader_if
  import instr_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W
) ();

  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  in_valid, in_byte,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_byte,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/byte_packer.sv
// byte_packer
// Purpose: assembles four bytes into a little-endian 32-bit word. Byte k of
// a word lands in bits [8k+7:8k].
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   clr       discard any partial word and restart at byte 0
//   take      a byte transfers this cycle
//   byte_in   the byte being transferred
//   word      assembled word (stable after the 4th byte until the next take)
//   complete  high in the cycle the 4th byte of a word is taken
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        complete
);

  logic [1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word  <= '0;
      count <= '0;
    end else if (take) begin
      word[{count, 3'b000} +: 8] <= byte_in;
      count                      <= count + 2'd1;
    end
  end

  assign complete = take && (count == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// instr_loader
// Purpose: loads a program into instruction memory from a byte stream.
// Bytes are packed into little-endian words and written from address 0
// upward; the core is held in reset until the load completes.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   start     one-cycle pulse that begins a load (honoured in IDLE or DONE)
//   nwords    words to load, sampled on start, clamped to DEPTH
//   bus       byte stream handshake + instruction memory write port
//   busy      load in progress
//   done      load finished, held until next start or rst
//   cpu_hold  core reset request, high from rst until done
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_RECV  | accepting bytes of the current word
// ST_WRITE | one-cycle write of the assembled word
// ST_DONE  | load complete, core released, start reloads
module instr_loader
  import instr_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W,
  parameter int DEPTH  = IM_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [7:0]     nwords,
  instr_loader_if.slave  bus,
  output logic           busy,
  output logic           done,
  output logic           cpu_hold
);

  loader_state_t     state_q, state_d;
  logic [7:0]        words_left;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        nw_clamped;
  logic              load;
  logic              in_ready_i, we_i, busy_i, done_i, hold_i;
  logic              take, complete;
  logic [31:0]       word;

  assign nw_clamped = clamp_nwords(nwords, DEPTH);
  assign take       = bus.in_valid && in_ready_i;

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (load),
    .take     (take),
    .byte_in  (bus.in_byte),
    .word     (word),
    .complete (complete)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    in_ready_i = 1'b0;
    we_i       = 1'b0;
    busy_i     = 1'b0;
    done_i     = 1'b0;
    hold_i     = 1'b1;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) begin
          done_i = 1'b1;
          hold_i = 1'b0;
        end
        if (start) begin
          load    = 1'b1;
          state_d = (nw_clamped == 8'd0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        in_ready_i = 1'b1;
        busy_i     = 1'b1;
        if (complete) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        we_i    = 1'b1;
        busy_i  = 1'b1;
        state_d = (words_left == 8'd1) ? ST_DONE : ST_RECV;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // words_left counts down to the final write; the address only advances
  // when another word follows, so it stops at the last written location
  // instead of wrapping after a full-depth load.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_left <= '0;
      addr_q     <= '0;
    end else if (load) begin
      words_left <= nw_clamped;
      addr_q     <= '0;
    end else if (state_q == ST_WRITE) begin
      words_left <= words_left - 8'd1;
      if (words_left != 8'd1) addr_q <= addr_q + ADDR_W'(1);
    end
  end

  // Outputs are forced to their reset values while rst is high so that no
  // write can land on the reset edge, even if rst arrives during ST_WRITE.
  assign bus.in_ready  = in_ready_i && !rst;
  assign bus.mem_we    = we_i && !rst;
  assign bus.mem_addr  = rst ? '0 : addr_q;
  assign bus.mem_wdata = (we_i && !rst) ? word : 32'd0;
  assign busy          = busy_i && !rst;
  assign done          = done_i && !rst;
  assign cpu_hold      = hold_i || rst;

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader
// Purpose: self-checking bench for instr_loader. Expected memory writes are
// queued as bytes are driven and popped by a write monitor.
module tb_instr_loader;
  import instr_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] nwords;
  logic       busy, done, cpu_hold;

  instr_loader_if #(.ADDR_W(IM_ADDR_W)) bus ();

  instr_loader #(.ADDR_W(IM_ADDR_W), .DEPTH(IM_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .nwords   (nwords),
    .bus      (bus.slave),
    .busy     (busy),
    .done     (done),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_writes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] word_of(input logic [7:0] base, input int i);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(int'(base) + 4*i + k);
    return w;
  endfunction

  // Write monitor: every mem_we cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (bus.mem_we === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(bus.mem_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
        chk("wr_data", bus.mem_wdata, e.data);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [7:0] nw);
    start  = 1'b1;
    nwords = nw;
    @(negedge clk);
    start  = 1'b0;
    nwords = 8'hAA;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    while (bus.in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    else @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'($urandom);
  endtask

  task automatic send_word(input logic [7:0] base, input int idx, input bit stall);
    logic [31:0] w;
    w = word_of(base, idx);
    exp_q.push_back('{addr: 7'(idx), data: w});
    for (int k = 0; k < 4; k++) begin
      if (stall) repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (done !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst = 1'b1;
    start = 1'b0;
    nwords = 8'd0;
    bus.in_valid = 1'b0;
    bus.in_byte = 8'd0;

    // Reset values
    do_reset();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);

    // Single word, back-to-back bytes, exact cycle timing
    pulse_start(8'd1);
    chk("sw_in_ready_after_start", 32'(bus.in_ready), 32'd1);
    chk("sw_busy", 32'(busy), 32'd1);
    exp_q.push_back('{addr: 7'd0, data: 32'h0050_0013});
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h50);
    send_byte(8'h00);
    chk("sw_we_after_4th", 32'(bus.mem_we), 32'd1);
    chk("sw_in_ready_in_write", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("sw_done", 32'(done), 32'd1);
    chk("sw_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("sw_busy_end", 32'(busy), 32'd0);
    chk("sw_n_writes", 32'(n_writes), 32'd1);

    // Full load, clamped length, random stalls
    w0 = n_writes;
    pulse_start(8'd200);
    for (int i = 0; i < 128; i++) send_word(8'h00, i, 1'b1);
    wait_done(20);
    repeat (5) @(negedge clk);
    chk("full_n_writes", 32'(n_writes), 32'(w0 + 128));
    chk("full_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("full_done_held", 32'(done), 32'd1);

    // Zero length
    do_reset();
    w0 = n_writes;
    pulse_start(8'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_cpu_hold", 32'(cpu_hold), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("zero_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    chk("zero_n_writes", 32'(n_writes), 32'(w0));

    // Mid-load reset after 2 bytes of word 3, then a 2-word reload
    w0 = n_writes;
    pulse_start(8'd6);
    for (int i = 0; i < 3; i++) send_word(8'h40, i, 1'b0);
    send_byte(8'hE1);
    send_byte(8'hE2);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("mr_rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("mr_rst_cpu_hold", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_idle_busy", 32'(busy), 32'd0);
    chk("mr_idle_done", 32'(done), 32'd0);
    chk("mr_idle_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("mr_idle_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mr_n_writes", 32'(n_writes), 32'(w0 + 3));
    pulse_start(8'd2);
    send_word(8'h90, 0, 1'b1);
    send_word(8'h90, 1, 1'b1);
    wait_done(20);
    repeat (2) @(negedge clk);
    chk("mr_reload_n_writes", 32'(n_writes), 32'(w0 + 5));
    chk("mr_queue_empty", 32'(exp_q.size()), 32'd0);

    // Start while busy is ignored; reload from DONE
    w0 = n_writes;
    pulse_start(8'd4);
    send_word(8'h20, 0, 1'b0);
    repeat (2) @(negedge clk);
    pulse_start(8'd1);
    chk("sb_busy_kept", 32'(busy), 32'd1);
    for (int i = 1; i < 4; i++) send_word(8'h20, i, 1'b1);
    wait_done(20);
    repeat (2) @(negedge clk);
    chk("sb_n_writes", 32'(n_writes), 32'(w0 + 4));
    w0 = n_writes;
    pulse_start(8'd2);
    chk("rl_done_drops", 32'(done), 32'd0);
    chk("rl_cpu_hold", 32'(cpu_hold), 32'd1);
    send_word(8'h33, 0, 1'b0);
    send_word(8'h33, 1, 1'b1);
    wait_done(20);
    repeat (2) @(negedge clk);
    chk("rl_n_writes", 32'(n_writes), 32'(w0 + 2));
    chk("rl_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
